// File: rtl/seq_signed_vedic_mult32_pkg.sv
// Shared definitions for the sequential signed Vedic multiplier:
// FSM states, nibble width and default operand width.
package vedic_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int NIB_W    = 4;
    localparam int OP_W_DEF = 32;
endpackage

// File: rtl/seq_signed_vedic_mult32_if.sv
// Operand/product handshake bundle for seq_signed_vedic_mult32.
interface seq_signed_vedic_mult32_if #(parameter int OP_W = vedic_pkg::OP_W_DEF);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [2*OP_W-1:0] p;

    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, p);
endinterface

// File: rtl/seq_signed_vedic_mult32_vedic4.sv
// Combinational 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier
// built from four 2x2 Vedic cells.
module vedic_mult_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
endmodule

module vedic_mult_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;

    vedic_mult_2bit u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_mult_2bit u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_mult_2bit u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_mult_2bit u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    // Cross products land at weight 4, the high pair at weight 16.
    assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// File: rtl/seq_signed_vedic_mult32.sv
// Sequential signed multiplier: one 4x4 Vedic nibble product per RUN cycle
// accumulated on magnitudes, sign applied once at the end.
module seq_signed_vedic_mult32
    import vedic_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input logic                      clk,
    input logic                      rst,
    seq_signed_vedic_mult32_if.slave bus
);
    localparam int NIBS  = OP_W / NIB_W;
    localparam int IDX_W = $clog2(NIBS);
    localparam int P_W   = 2 * OP_W;

    state_e             state, state_nxt;
    logic [OP_W-1:0]    ma, mb;
    logic               sgn;
    logic [P_W-1:0]     acc, p_q, pp_sh;
    logic [IDX_W-1:0]   i_q, j_q;
    logic [NIB_W-1:0]   na, nb;
    logic [2*NIB_W-1:0] pp;
    logic [IDX_W+2:0]   sh;
    logic               last, accept;

    // |-2^(OP_W-1)| wraps to 2^(OP_W-1), which fits an unsigned OP_W field.
    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] x);
        return x[OP_W-1] ? (~x + OP_W'(1)) : x;
    endfunction

    assign na     = ma[NIB_W*i_q +: NIB_W];
    assign nb     = mb[NIB_W*j_q +: NIB_W];
    assign sh     = {({1'b0, i_q} + {1'b0, j_q}), 2'b00};
    assign pp_sh  = {{(P_W-2*NIB_W){1'b0}}, pp} << sh;
    assign last   = (i_q == IDX_W'(NIBS-1)) && (j_q == IDX_W'(NIBS-1));
    assign accept = (state == IDLE) && bus.in_valid;

    vedic_mult_4bit u_v4 (.a(na), .b(nb), .p(pp));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = RUN;
            RUN:  if (last)         state_nxt = SIGN;
            SIGN:                   state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ma    <= '0;
            mb    <= '0;
            sgn   <= 1'b0;
            acc   <= '0;
            p_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ma  <= mag(bus.a);
                mb  <= mag(bus.b);
                sgn <= bus.a[OP_W-1] ^ bus.b[OP_W-1];
                acc <= '0;
                i_q <= '0;
                j_q <= '0;
            end else if (state == RUN) begin
                acc <= acc + pp_sh;
                j_q <= j_q + IDX_W'(1);
                if (j_q == IDX_W'(NIBS-1))
                    i_q <= i_q + IDX_W'(1);
            end else if (state == SIGN) begin
                // Negating a zero magnitude yields zero, so no -0 can appear.
                p_q <= sgn ? (~acc + P_W'(1)) : acc;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.p         = p_q;
endmodule
